// File: rtl/sfu_accum.sv
// Multi-pass psum accumulator with saturating/ReLU drain behind the OFIFO.
// Optional sticky per-channel saturation flags: define SFU_SAT_FLAG_EN.
module sfu_accum #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int acc_bw  = 20,
  parameter int depth   = 16,
  parameter int pass_bw = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [pass_bw-1:0]     num_pass,
  input  logic                   relu_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*psum_bw-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   busy,
  output logic                   done
`ifdef SFU_SAT_FLAG_EN
  ,output logic [col-1:0]        sat_flag
`endif
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [aw-1:0]      LAST  = aw'(depth - 1);
  localparam logic [pass_bw-1:0] ONE_P = pass_bw'(1);
  localparam logic signed [acc_bw-1:0] SMAX =
    {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
  localparam logic signed [acc_bw-1:0] SMIN =
    {{(acc_bw-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [aw-1:0]        widx_q, widx_d, ridx_q, ridx_d;
  logic [pass_bw-1:0]   pass_q, pass_d, np_q, np_d;
  logic                 relu_q, relu_d, done_q, done_d;
  logic                 bank_we;
  logic signed [acc_bw-1:0] bank_q [depth][col];
  logic signed [acc_bw-1:0] wr_d [col];
  logic [col*psum_bw-1:0]   drain_data;
`ifdef SFU_SAT_FLAG_EN
  logic [col-1:0]       sat_hit, sat_q, sat_d;
`endif

  always_comb begin : p_datapath
    logic signed [acc_bw-1:0]  ext, acc;
    logic signed [psum_bw-1:0] res;
    ext        = '0;
    acc        = '0;
    res        = '0;
    wr_d       = '{default: '0};
    drain_data = '0;
`ifdef SFU_SAT_FLAG_EN
    sat_hit    = '0;
`endif
    for (int unsigned c = 0; c < col; c++) begin
      ext = {{(acc_bw-psum_bw){in_data[c*psum_bw + psum_bw - 1]}},
             in_data[c*psum_bw +: psum_bw]};
      // Pass 0 overwrites, so the bank never needs clearing between runs.
      wr_d[c] = (pass_q == '0) ? ext : bank_q[widx_q][c] + ext;

      acc = bank_q[ridx_q][c];
      if (acc > SMAX)      res = SMAX[psum_bw-1:0];
      else if (acc < SMIN) res = SMIN[psum_bw-1:0];
      else                 res = acc[psum_bw-1:0];
      if (relu_q && res[psum_bw-1]) res = '0;
      drain_data[c*psum_bw +: psum_bw] = res;
`ifdef SFU_SAT_FLAG_EN
      sat_hit[c] = (acc > SMAX) || (acc < SMIN);
`endif
    end
  end

  always_comb begin : p_fsm
    state_d = state_q;
    widx_d  = widx_q;
    ridx_d  = ridx_q;
    pass_d  = pass_q;
    np_d    = np_q;
    relu_d  = relu_q;
    done_d  = 1'b0;
    bank_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          np_d    = (mode || num_pass == '0) ? ONE_P : num_pass;
          relu_d  = relu_en;
          widx_d  = '0;
          pass_d  = '0;
          ridx_d  = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          bank_we = 1'b1;
          widx_d  = widx_q + 1'b1;
          if (widx_q == LAST) begin
            widx_d = '0;
            pass_d = pass_q + ONE_P;
            if (pass_q == np_q - ONE_P) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          ridx_d = ridx_q + 1'b1;
          if (ridx_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SFU_SAT_FLAG_EN
  always_comb begin
    sat_d = sat_q;
    if (state_q == IDLE && start)            sat_d = '0;
    else if (state_q == DRAIN && out_ready)  sat_d = sat_q | sat_hit;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      widx_q  <= '0;
      ridx_q  <= '0;
      pass_q  <= '0;
      np_q    <= '0;
      relu_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SFU_SAT_FLAG_EN
      sat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      pass_q  <= pass_d;
      np_q    <= np_d;
      relu_q  <= relu_d;
      done_q  <= done_d;
`ifdef SFU_SAT_FLAG_EN
      sat_q   <= sat_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (bank_we) begin
      for (int unsigned c = 0; c < col; c++) bank_q[widx_q][c] <= wr_d[c];
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_data  = (state_q == DRAIN) ? drain_data : '0;
`ifdef SFU_SAT_FLAG_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_sfu_accum.sv
// Directed table-driven bench for sfu_accum (depth=4 instance plus a default
// instance for the reset/idle checks).
module tb_sfu_accum;
  localparam int COL = 8;
  localparam int PW  = 16;
  localparam int D   = 4;
  localparam int PB  = 4;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0, relu_en = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [PB-1:0] num_pass = '0;
  logic [COL*PW-1:0] in_data = '0;
  logic in_ready, out_valid, busy, done;
  logic [COL*PW-1:0] out_data;
  logic d_in_ready, d_out_valid, d_busy, d_done;
  logic [COL*PW-1:0] d_out_data;
`ifdef SFU_SAT_FLAG_EN
  logic [COL-1:0] sat_flag, d_sat_flag;
`endif

  always #5 clk = ~clk;

  sfu_accum #(.depth(D)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_pass(num_pass),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
`ifdef SFU_SAT_FLAG_EN
    , .sat_flag(sat_flag)
`endif
  );

  sfu_accum u_def (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_pass(num_pass),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
    .busy(d_busy), .done(d_done)
`ifdef SFU_SAT_FLAG_EN
    , .sat_flag(d_sat_flag)
`endif
  );

  typedef struct {
    int mode, num_pass, np, relu;
    int a0, a1, a2, b0, b1, b2;   // ch0 / ch1 input per pass
    int e0, e1;                   // hand-computed ch0 / ch1 result
    int sat;                      // expected sat_flag mask
    int gaps, bp, mid_start;
  } rec_t;

  rec_t tbl [7];
  int n_cmp = 0, n_err = 0, done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic rec_t mk(int md, int nps, int np, int rl, int a0, int a1, int a2,
                              int b0, int b1, int b2, int e0, int e1, int sat,
                              int gaps, int bp, int ms);
    rec_t t;
    t.mode = md; t.num_pass = nps; t.np = np; t.relu = rl;
    t.a0 = a0; t.a1 = a1; t.a2 = a2; t.b0 = b0; t.b1 = b1; t.b2 = b2;
    t.e0 = e0; t.e1 = e1; t.sat = sat; t.gaps = gaps; t.bp = bp; t.mid_start = ms;
    return t;
  endfunction

  task automatic chk(input string name, input logic [COL*PW-1:0] act,
                     input logic [COL*PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Channels 2..7 carry p+1+c*e so every bank entry differs.
  function automatic int in_val(int r, int p, int c, int e);
    if (c == 0) return (p == 0) ? tbl[r].a0 : (p == 1) ? tbl[r].a1 : tbl[r].a2;
    if (c == 1) return (p == 0) ? tbl[r].b0 : (p == 1) ? tbl[r].b1 : tbl[r].b2;
    return p + 1 + c * e;
  endfunction

  function automatic logic [COL*PW-1:0] in_vec(int r, int p, int e);
    logic [COL*PW-1:0] v = '0;
    for (int c = 0; c < COL; c++) v[c*PW +: PW] = PW'(in_val(r, p, c, e));
    return v;
  endfunction

  function automatic int post(int s, int relu);
    int v = s;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    if (relu != 0 && v < 0) v = 0;
    return v;
  endfunction

  function automatic logic [COL*PW-1:0] exp_vec(int r, int e);
    logic [COL*PW-1:0] v = '0;
    int np = tbl[r].np;
    v[0 +: PW]  = PW'(tbl[r].e0);
    v[PW +: PW] = PW'(tbl[r].e1);
    for (int c = 2; c < COL; c++)
      v[c*PW +: PW] = PW'(post(np * (np + 1) / 2 + np * c * e, tbl[r].relu));
    return v;
  endfunction

  task automatic run_rec(input int r, input int abort_at);
    rec_t t = tbl[r];
    int beat = 0, waitc = 0, d0;
    mode = (t.mode != 0); num_pass = PB'(t.num_pass); relu_en = (t.relu != 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    chk("busy_after_start", busy, 1);
    chk("in_ready_accum", in_ready, 1);
`ifdef SFU_SAT_FLAG_EN
    chk("sat_cleared_on_start", sat_flag, 0);
`endif
    for (int p = 0; p < t.np; p++) begin
      for (int e = 0; e < D; e++) begin
        if (t.gaps[beat]) begin
          in_valid = 1'b0;
          @(negedge clk);
          chk("stall_no_out_valid", out_valid, 0);
        end
        in_valid = 1'b1;
        in_data  = in_vec(r, p, e);
        start    = (t.mid_start != 0 && beat == 2);
        @(negedge clk);
        start = 1'b0;
        beat++;
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk("drain_latency", out_valid, 1);
    while (!out_valid && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!out_valid) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got out_valid=0 want 1 within 20 cycles");
      reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
      return;
    end
    for (int e = 0; e < D; e++) begin
      chk("drain_data", out_data, exp_vec(r, e));
      if (e == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_done_after_reset", done_cnt - d0, 0);
        return;
      end
      if (t.bp != 0 && e == 1) begin
        repeat (3) begin
          out_ready = 1'b0;
          @(negedge clk);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_data_hold", out_data, exp_vec(r, 1));
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_after_drain", busy, 0);
    chk("out_valid_after_drain", out_valid, 0);
    chk("out_data_idle", out_data, 0);
`ifdef SFU_SAT_FLAG_EN
    chk("sat_flag", sat_flag, COL'(t.sat));
`endif
    @(negedge clk);
    chk("done_single_cycle", done, 0);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        md nps np rl   a0     a1     a2     b0      b1      b2      e0     e1    sat gaps  bp ms
    tbl[0] = mk(0, 3, 3, 0,     1,     2,     3,      1,      2,      3,     6,     6,   0, 'h88, 1, 0);
    tbl[1] = mk(0, 2, 2, 0,    -5,    -3,     0,      7,     -2,      0,    -8,     5,   0,    0, 0, 0);
    tbl[2] = mk(0, 2, 2, 1,    -5,    -3,     0,      7,     -2,      0,     0,     5,   0,    0, 0, 0);
    tbl[3] = mk(0, 3, 3, 0, 20000, 20000, 20000, -20000, -20000, -20000, 32767, -32768, 3,    0, 0, 0);
    tbl[4] = mk(1, 5, 1, 0,    11,     0,     0,    -12,      0,      0,    11,   -12,   0,    0, 1, 1);
    tbl[5] = mk(0, 0, 1, 0,     9,     0,     0,     -1,      0,      0,     9,    -1,   0,    0, 0, 0);
    tbl[6] = mk(0, 1, 1, 0,    -7,     0,     0,     40,      0,      0,    -7,    40,   0,    0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_out_data", out_data, 0);
    chk("def_idle_in_ready", d_in_ready, 0);
    chk("def_idle_out_valid", d_out_valid, 0);
    chk("def_idle_busy", d_busy, 0);
    chk("def_idle_done", d_done, 0);
    chk("def_idle_out_data", d_out_data, 0);
    in_valid = 1'b1;
    in_data  = '1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_valid_busy", busy, 0);
      chk("idle_in_valid_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    in_data  = '0;

    for (int r = 0; r < 6; r++) run_rec(r, -1);
    run_rec(6, 2);
    run_rec(6, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
